ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader_pkg.sv | 24 ++
 rtl/ram_stream_reader_if.sv | 47 ++++
 rtl/ram_stream_reader_fifo.sv | 83 ++++++++
 rtl/ram_stream_reader.sv | 156 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// +------------------------------------------------------------------+
// | ram_stream_pkg                                                   |
// | Shared types and sizing for the RAM stream reader.               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  // Two stages between issue and push: address register and RAM output register.
  localparam int INFLIGHT_W = 2;

endpackage

`default_nettype wire

// File: rtl/ram_stream_reader_if.sv
// +------------------------------------------------------------------+
// | ram_stream_reader_if                                             |
// | Command, RAM read port and output stream of the reader.          |
// | Optional abort line under RAM_STREAM_ABORT_EN.                   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface ram_stream_reader_if #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) ();

  logic               start;
  logic [A_WIDTH-1:0] start_addr;
  logic [A_WIDTH:0]   length;
  logic               busy;
  logic               done;
`ifdef RAM_STREAM_ABORT_EN
  logic               abort;
`endif
  logic [A_WIDTH-1:0] address_read;
  logic [D_WIDTH-1:0] data_read;
  logic               m_valid;
  logic               m_ready;
  logic [D_WIDTH-1:0] m_data;
  logic               m_last;

  modport master (
    input  start, start_addr, length, data_read, m_ready,
`ifdef RAM_STREAM_ABORT_EN
    input  abort,
`endif
    output busy, done, address_read, m_valid, m_data, m_last
  );

  modport slave (
    output start, start_addr, length, data_read, m_ready,
`ifdef RAM_STREAM_ABORT_EN
    output abort,
`endif
    input  busy, done, address_read, m_valid, m_data, m_last
  );

endinterface

`default_nettype wire

// File: rtl/ram_stream_reader_fifo.sv
// +------------------------------------------------------------------+
// | stream_fifo                                                      |
// | FIFO_DEPTH-entry synchronous FIFO with flush and occupancy count.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module stream_fifo
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  flush,
  input  wire logic                  push,
  input  wire logic [WIDTH-1:0]      push_data,
  input  wire logic                  pop,
  output logic      [WIDTH-1:0]      pop_data,
  output logic                       valid,
  output logic      [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]      mem_d [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != FIFO_CNT_W'(FIFO_DEPTH));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + FIFO_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + FIFO_CNT_W'(1);
        2'b01:   count_d = count_q - FIFO_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output forced to zero when empty so the stream idles at all-zero.
  assign valid    = (count_q != '0);
  assign pop_data = valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

`default_nettype wire

// File: rtl/ram_stream_reader.sv
// +------------------------------------------------------------------+
// | ram_stream_reader                                                |
// | Burst reader for a 1-cycle-latency RAM onto a valid/ready stream.|
// | Optional feature macro: RAM_STREAM_ABORT_EN (abort input).       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input wire logic            clk,
  input wire logic            rst_n,
  ram_stream_reader_if.master bus
);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [A_WIDTH-1:0] address_read_q, address_read_d;
  logic [A_WIDTH:0]   remaining_q, remaining_d;
  logic               issued_q, issued_d;
  logic               issued_last_q, issued_last_d;
  logic               ram_valid_q, ram_valid_d;
  logic               ram_last_q, ram_last_d;
  logic               done_q, done_d;

  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [INFLIGHT_W-1:0] inflight;
  logic [D_WIDTH:0]      fifo_out;
  logic                  fifo_valid;
  logic                  fifo_pop;
  logic                  fifo_push;
  logic                  flush;
  logic                  credit_ok;
  logic                  abort_hit;

`ifdef RAM_STREAM_ABORT_EN
  assign abort_hit = bus.abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign inflight  = INFLIGHT_W'(issued_q) + INFLIGHT_W'(ram_valid_q);
  // Credit uses registered occupancy only; a same-cycle pop is not counted.
  assign credit_ok = (fifo_count + FIFO_CNT_W'(inflight)) < FIFO_CNT_W'(FIFO_DEPTH);
  assign fifo_pop  = fifo_valid && bus.m_ready;
  assign fifo_push = ram_valid_q;

  always_comb begin
    state_d        = state_q;
    next_addr_d    = next_addr_q;
    address_read_d = address_read_q;
    remaining_d    = remaining_q;
    issued_d       = 1'b0;
    issued_last_d  = 1'b0;
    ram_valid_d    = issued_q;
    ram_last_d     = issued_last_q;
    done_d         = 1'b0;
    flush          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            next_addr_d = bus.start_addr;
            remaining_d = bus.length;
          end
        end
      end
      RUN: begin
        if (credit_ok) begin
          address_read_d = next_addr_q;
          next_addr_d    = next_addr_q + A_WIDTH'(1);
          remaining_d    = remaining_q - (A_WIDTH+1)'(1);
          issued_d       = 1'b1;
          if (remaining_q == (A_WIDTH+1)'(1)) begin
            issued_last_d = 1'b1;
            state_d       = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_pop && fifo_out[D_WIDTH]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_hit) begin
      state_d       = IDLE;
      done_d        = 1'b1;
      flush         = 1'b1;
      remaining_d   = '0;
      issued_d      = 1'b0;
      issued_last_d = 1'b0;
      ram_valid_d   = 1'b0;
      ram_last_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      next_addr_q    <= '0;
      address_read_q <= '0;
      remaining_q    <= '0;
      issued_q       <= 1'b0;
      issued_last_q  <= 1'b0;
      ram_valid_q    <= 1'b0;
      ram_last_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_addr_q    <= next_addr_d;
      address_read_q <= address_read_d;
      remaining_q    <= remaining_d;
      issued_q       <= issued_d;
      issued_last_q  <= issued_last_d;
      ram_valid_q    <= ram_valid_d;
      ram_last_q     <= ram_last_d;
      done_q         <= done_d;
    end
  end

  stream_fifo #(
    .WIDTH (D_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data ({ram_last_q, bus.data_read}),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.address_read = address_read_q;
  assign bus.m_valid      = fifo_valid;
  assign bus.m_data       = fifo_out[D_WIDTH-1:0];
  assign bus.m_last       = fifo_valid && fifo_out[D_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// +------------------------------------------------------------------+
// | tb_ram_stream_reader                                             |
// | Directed self-checking bench; abort steps under RAM_STREAM_ABORT_EN.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ram_stream_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] mem [32];

  ram_stream_reader_if #(.D_WIDTH(16), .A_WIDTH(5)) bus ();

  ram_stream_reader #(.D_WIDTH(16), .A_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.data_read <= mem[bus.address_read];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge just after start is cleared; ends one cycle after done.
  task automatic collect(input int a, input int len);
    int  got;
    bit  seen_done;
    got = 0;
    seen_done = 0;
    for (int k = 0; k < 100 && !seen_done; k++) begin
      if (bus.m_valid) begin
        chk("burst_data", 32'(bus.m_data), 32'(16'h1000 + ((a + got) % 32)));
        chk("burst_last", 32'(bus.m_last), 32'(got == len - 1));
        got++;
      end
      if (bus.done) seen_done = 1;
      else @(negedge clk);
    end
    chk("burst_count", got, len);
    chk("burst_done", 32'(seen_done), 1);
    @(negedge clk);
  endtask

  task automatic run_burst(input int a, input int len);
    bus.start      = 1'b1;
    bus.start_addr = 5'(a);
    bus.length     = 6'(len);
    bus.m_ready    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    collect(a, len);
  endtask

  function automatic bit ready_at(input int i);
    return (i == 0) || (i == 3) || (i >= 14);
  endfunction

  int          wa [4];
  int          got;
  bit          seen_done;
  bit          stall_prev;
  logic [15:0] prev_data;
  logic        prev_last;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.length     = '0;
    bus.m_ready    = 1'b0;
`ifdef RAM_STREAM_ABORT_EN
    bus.abort      = 1'b0;
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_valid", 32'(bus.m_valid), 0);
    chk("rst_last", 32'(bus.m_last), 0);
    chk("rst_data", 32'(bus.m_data), 0);
    chk("rst_addr", 32'(bus.address_read), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst: addr 3, length 5, latency and back-to-back words
    bus.start = 1'b1; bus.start_addr = 5'd3; bus.length = 6'd5; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b1_busy", 32'(bus.busy), 1);
    chk("b1_valid_e1", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("b1_addr0", 32'(bus.address_read), 3);
    chk("b1_valid_e2", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("b1_valid_e3", 32'(bus.m_valid), 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("b1_valid", 32'(bus.m_valid), 1);
      chk("b1_data", 32'(bus.m_data), 32'(16'h1003 + 16'(j)));
      chk("b1_last", 32'(bus.m_last), 32'(j == 4));
    end
    @(negedge clk);
    chk("b1_done", 32'(bus.done), 1);
    chk("b1_busy_end", 32'(bus.busy), 0);
    chk("b1_valid_end", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("b1_done_pulse", 32'(bus.done), 0);

    // Address wrap: 30, 31, 0, 1
    wa[0] = 30; wa[1] = 31; wa[2] = 0; wa[3] = 1;
    bus.start = 1'b1; bus.start_addr = 5'd30; bus.length = 6'd4;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (j >= 1 && j <= 4) chk("wrap_addr", 32'(bus.address_read), wa[j-1]);
      if (j >= 3 && j <= 6) begin
        chk("wrap_valid", 32'(bus.m_valid), 1);
        chk("wrap_data", 32'(bus.m_data), 32'(16'h1000 + 16'(wa[j-3])));
        chk("wrap_last", 32'(bus.m_last), 32'(j == 6));
      end
      if (j == 7) chk("wrap_done", 32'(bus.done), 1);
    end
    @(negedge clk);

    // Backpressure: ready 1-0-0-1 then low for 10 cycles
    bus.start = 1'b1; bus.start_addr = 5'd8; bus.length = 6'd8; bus.m_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    got = 0; seen_done = 0; stall_prev = 0; prev_data = '0; prev_last = 1'b0;
    for (int i = 0; i < 80 && !seen_done; i++) begin
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.m_valid), 1);
        chk("stall_data", 32'(bus.m_data), 32'(prev_data));
        chk("stall_last", 32'(bus.m_last), 32'(prev_last));
      end
      if (i == 13) chk("credit_stop_addr", 32'(bus.address_read), 12);
      if (bus.done) seen_done = 1;
      else begin
        bus.m_ready = ready_at(i);
        if (bus.m_valid && bus.m_ready) begin
          chk("bp_data", 32'(bus.m_data), 32'(16'h1008 + 16'(got)));
          chk("bp_last", 32'(bus.m_last), 32'(got == 7));
          got++;
        end
        stall_prev = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        @(negedge clk);
      end
    end
    chk("bp_count", got, 8);
    chk("bp_done", 32'(seen_done), 1);
    @(negedge clk);
    chk("bp_idle_valid", 32'(bus.m_valid), 0);
    chk("bp_idle_busy", 32'(bus.busy), 0);

    // Zero length: done only
    bus.m_ready = 1'b1;
    bus.start = 1'b1; bus.start_addr = 5'd4; bus.length = 6'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("len0_done", 32'(bus.done), 1);
    chk("len0_busy", 32'(bus.busy), 0);
    chk("len0_valid", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("len0_done_pulse", 32'(bus.done), 0);
    chk("len0_busy2", 32'(bus.busy), 0);
    chk("len0_valid2", 32'(bus.m_valid), 0);

    // Start while busy is ignored
    bus.start = 1'b1; bus.start_addr = 5'd0; bus.length = 6'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = 5'd20; bus.length = 6'd2;
    @(negedge clk);
    bus.start = 1'b0;
    collect(0, 3);
    for (int j = 0; j < 6; j++) begin
      chk("nq_valid", 32'(bus.m_valid), 0);
      chk("nq_busy", 32'(bus.busy), 0);
      @(negedge clk);
    end

    // Reset during third word of a 6-word burst
    bus.start = 1'b1; bus.start_addr = 5'd0; bus.length = 6'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_data", 32'(bus.m_data), 32'h1002);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_valid", 32'(bus.m_valid), 0);
    chk("arst_last", 32'(bus.m_last), 0);
    chk("arst_data", 32'(bus.m_data), 0);
    chk("arst_addr", 32'(bus.address_read), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(bus.done), 0);
    run_burst(0, 2);

    // Full address space
    run_burst(7, 32);

`ifdef RAM_STREAM_ABORT_EN
    // Abort after two handshakes of a 10-word burst
    bus.start = 1'b1; bus.start_addr = 5'd0; bus.length = 6'd10; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_w0", 32'(bus.m_data), 32'h1000);
    @(negedge clk);
    chk("ab_w1", 32'(bus.m_data), 32'h1001);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab_valid", 32'(bus.m_valid), 0);
    chk("ab_last", 32'(bus.m_last), 0);
    chk("ab_done", 32'(bus.done), 1);
    chk("ab_busy", 32'(bus.busy), 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("ab_quiet_valid", 32'(bus.m_valid), 0);
      chk("ab_quiet_done", 32'(bus.done), 0);
    end
    run_burst(5, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
